// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 (modified) Booth multiplier. Two multiplier bits are
// retired per clock, with valid/ready handshakes on operand and result sides.
module booth_r4_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int STEPS = WIDTH/2 + 1;
  localparam int XW    = WIDTH + 2;
  localparam int ACC_W = 2*WIDTH + 4;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [XW-1:0]    mcand;
  logic [XW:0]      mplier;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] step;

  logic             in_fire, out_fire, last_step;
  logic [XW-1:0]    a_x, b_x;
  logic [ACC_W-1:0] a_acc, pp, pp_sh, acc_nxt;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a held valid keeps its data.
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_step = (step == LAST_STEP);

  assign a_x = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign b_x = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire)   state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (out_fire)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Booth recoding of the low three multiplier bits into {0, +-A, +-2A}
  assign a_acc = {{(ACC_W-XW){mcand[XW-1]}}, mcand};

  always_comb begin
    pp = '0;
    case (mplier[2:0])
      3'b001, 3'b010: pp = a_acc;
      3'b011:         pp = a_acc << 1;
      3'b100:         pp = -(a_acc << 1);
      3'b101, 3'b110: pp = -a_acc;
      default:        pp = '0;
    endcase
  end

  assign pp_sh   = pp << {step, 1'b0};
  assign acc_nxt = acc + pp_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      step    <= '0;
      product <= '0;
    end else if (in_fire) begin
      mcand  <= a_x;
      mplier <= {b_x, 1'b0};
      acc    <= '0;
      step   <= '0;
    end else if (state == CALC) begin
      acc    <= acc_nxt;
      mplier <= {{2{mplier[XW]}}, mplier[XW:2]};
      step   <= step + CNT_W'(1);
      if (last_step) product <= acc_nxt[2*WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult: directed corner cases on a 32-bit instance plus
// randomised sweeps of 32-bit and 8-bit instances against an arithmetic model.
module tb_booth_r4_seq_mult;
  localparam int STEPS32 = 17;
  localparam int STEPS8  = 5;
  localparam int TMO     = 200;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid32, in_ready32, sg32, out_valid32, out_ready32;
  logic [31:0] a32, b32;
  logic [63:0] product32;
  logic        in_valid8, in_ready8, sg8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  booth_r4_seq_mult #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .is_signed(sg32), .out_valid(out_valid32),
    .out_ready(out_ready32), .product(product32)
  );

  booth_r4_seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .is_signed(sg8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(product8)
  );

  // scoreboard
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] c32 [5];
  logic [7:0]  c8 [5];
  logic [31:0] av32, bv32;
  logic [7:0]  av8, bv8;
  logic        sgr;
  logic [63:0] expv;

  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic sg);
    logic [63:0] xx, yy;
    xx = sg ? {{32{x[31]}}, x} : {32'b0, x};
    yy = sg ? {{32{y[31]}}, y} : {32'b0, y};
    return xx * yy;
  endfunction

  function automatic logic [63:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic sg);
    logic [15:0] xx, yy, pr;
    xx = sg ? {{8{x[7]}}, x} : {8'b0, x};
    yy = sg ? {{8{y[7]}}, y} : {8'b0, y};
    pr = xx * yy;
    return {48'b0, pr};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic abort(input string tag);
    n_checks++;
    n_err++;
    $display("FAIL %s: got no DUT event within %0d cycles, expected one", tag, TMO);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  endtask

  // driver: issue one 32-bit operation, scramble operands after accept, collect result
  task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                      input logic [63:0] ev, input string tag);
    int cyc;
    cyc = 0;
    while (!in_ready32) begin
      @(posedge clk); #1; cyc++;
      if (cyc > TMO) abort({tag, "_issue"});
    end
    a32 = av; b32 = bv; sg32 = sg; in_valid32 = 1'b1;
    exp_q.push_back(ev);
    @(posedge clk); #1;
    in_valid32 = 1'b0; a32 = $urandom; b32 = $urandom; sg32 = ~sg;
    cyc = 0;
    while (!out_valid32) begin
      @(posedge clk); #1; cyc++;
      if (cyc > TMO) abort({tag, "_result"});
    end
    check({tag, "_lat"}, 64'(cyc), 64'(STEPS32));
    check({tag, "_prod"}, product32, exp_q.pop_front());
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    check({tag, "_idle"}, {62'b0, out_valid32, in_ready32}, 64'h1);
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sg,
                     input logic [63:0] ev, input string tag);
    int cyc;
    cyc = 0;
    while (!in_ready8) begin
      @(posedge clk); #1; cyc++;
      if (cyc > TMO) abort({tag, "_issue"});
    end
    a8 = av; b8 = bv; sg8 = sg; in_valid8 = 1'b1;
    exp_q.push_back(ev);
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = ~sg;
    cyc = 0;
    while (!out_valid8) begin
      @(posedge clk); #1; cyc++;
      if (cyc > TMO) abort({tag, "_result"});
    end
    check({tag, "_lat"}, 64'(cyc), 64'(STEPS8));
    check({tag, "_prod"}, {48'b0, product8}, exp_q.pop_front());
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check({tag, "_idle"}, {62'b0, out_valid8, in_ready8}, 64'h1);
  endtask

  initial begin
    c32 = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    c8  = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h7F};
    in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0; sg32 = 1'b0;
    in_valid8  = 1'b0; out_ready8  = 1'b0; a8  = '0; b8  = '0; sg8  = 1'b0;
    rst_n = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_prod32", product32, 64'h0);
    check("rst_ov32", {63'b0, out_valid32}, 64'h0);
    check("rst_prod8", {48'b0, product8}, 64'h0);
    check("rst_ov8", {63'b0, out_valid8}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rdy32", {63'b0, in_ready32}, 64'h1);
    check("rst_rdy8", {63'b0, in_ready8}, 64'h1);

    // directed arithmetic corners
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax");
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "smin");
    op32(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "neg21");

    // back-pressure with ignored in_valid pulses during CALC and DONE
    expv = 64'h0B00_EA4E_242D_2080;
    a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; sg32 = 1'b0; in_valid32 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < STEPS32 - 1; i++) begin
      a32 = $urandom; b32 = $urandom; in_valid32 = 1'b1;
      check("bp_calc_rdy", {63'b0, in_ready32}, 64'h0);
      @(posedge clk); #1;
    end
    in_valid32 = 1'b0;
    @(posedge clk); #1;
    check("bp_ov", {63'b0, out_valid32}, 64'h1);
    check("bp_prod", product32, expv);
    for (int i = 0; i < 10; i++) begin
      in_valid32 = (i % 2 == 1);
      @(posedge clk); #1;
      check("bp_hold_prod", product32, expv);
      check("bp_hold_ov_rdy", {62'b0, out_valid32, in_ready32}, 64'h2);
    end
    in_valid32 = 1'b0; out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    check("bp_release", {62'b0, out_valid32, in_ready32}, 64'h1);
    repeat (STEPS32 + 3) @(posedge clk);
    #1;
    check("bp_no_queue", {62'b0, out_valid32, in_ready32}, 64'h1);

    // asynchronous reset in the middle of a calculation
    op32(32'd1000, 32'd1000, 1'b0, 64'd1000000, "pre_rst");
    a32 = 32'hDEAD_BEEF; b32 = 32'h0000_1234; sg32 = 1'b0; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_prod", product32, 64'h0);
    check("rst_mid_ov", {63'b0, out_valid32}, 64'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_rdy", {63'b0, in_ready32}, 64'h1);
    repeat (STEPS32 + 5) @(posedge clk);
    #1;
    check("rst_no_stale", {63'b0, out_valid32}, 64'h0);
    op32(32'd6, 32'd7, 1'b0, 64'd42, "post_rst");

    // corner grid, both widths and both modes
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int s = 0; s < 2; s++) begin
          op32(c32[i], c32[j], 1'(s), ref32(c32[i], c32[j], 1'(s)), "grid32");
          op8(c8[i], c8[j], 1'(s), ref8(c8[i], c8[j], 1'(s)), "grid8");
        end

    // randomised sweeps with occasional corner operands
    for (int n = 0; n < 1500; n++) begin
      av32 = ($urandom_range(0, 7) == 0) ? c32[$urandom_range(0, 4)] : $urandom;
      bv32 = ($urandom_range(0, 7) == 0) ? c32[$urandom_range(0, 4)] : $urandom;
      sgr  = 1'($urandom_range(0, 1));
      op32(av32, bv32, sgr, ref32(av32, bv32, sgr), "rand32");
    end
    for (int n = 0; n < 3000; n++) begin
      av8 = ($urandom_range(0, 7) == 0) ? c8[$urandom_range(0, 4)] : 8'($urandom);
      bv8 = ($urandom_range(0, 7) == 0) ? c8[$urandom_range(0, 4)] : 8'($urandom);
      sgr = 1'($urandom_range(0, 1));
      op8(av8, bv8, sgr, ref8(av8, bv8, sgr), "rand8");
    end

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
